// File: rtl/display_timing_gen.sv
// Display timing generator: free-running pixel coordinates with registered,
// mutually coherent sync, data-enable, line/frame/vblank strobes and frame counter.
module display_timing_gen #(
    parameter int   CORDW  = 10,
    parameter int   H_RES  = 640,
    parameter int   H_FP   = 16,
    parameter int   H_SYNC = 96,
    parameter int   H_BP   = 48,
    parameter int   V_RES  = 480,
    parameter int   V_FP   = 10,
    parameter int   V_SYNC = 2,
    parameter int   V_BP   = 33,
    parameter logic H_POL  = 1'b0,
    parameter logic V_POL  = 1'b0,
    parameter int   FCNTW  = 16
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame,
    output logic             vblank_start,
    output logic [FCNTW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_FIRST = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_LAST  = CORDW'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [CORDW-1:0] VS_FIRST = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_LAST  = CORDW'(V_RES + V_FP + V_SYNC - 1);

    if ((2 ** CORDW) < H_TOTAL || (2 ** CORDW) < V_TOTAL) begin : g_bad_cordw
        $error("display_timing_gen: CORDW too narrow for the frame totals");
    end
    if (H_RES == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_RES == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
        $error("display_timing_gen: timing parameters must be non-zero");
    end

    logic [CORDW-1:0] nx;
    logic [CORDW-1:0] ny;
    logic             n_hs;
    logic             n_vs;
    logic             n_de;
    logic             n_line;
    logic             n_frame;
    logic             n_vblank;

    // Decode the position the registers will hold next, so every registered
    // output on a cycle describes the same (sx, sy) with no skew.
    always_comb begin
        nx = sx + 1'b1;
        ny = sy;
        if (sx == H_LAST) begin
            nx = '0;
            ny = (sy == V_LAST) ? '0 : sy + 1'b1;
        end
        n_hs     = (nx >= HS_FIRST) && (nx <= HS_LAST);
        n_vs     = (ny >= VS_FIRST) && (ny <= VS_LAST);
        n_de     = (nx < H_ACT) && (ny < V_ACT);
        n_line   = (nx == '0);
        n_frame  = (nx == '0) && (ny == '0);
        n_vblank = (nx == '0) && (ny == V_ACT);
    end

    // Reset parks the counters on the last pixel so the first edge lands on (0, 0).
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            sx           <= H_LAST;
            sy           <= V_LAST;
            hsync        <= ~H_POL;
            vsync        <= ~V_POL;
            de           <= 1'b0;
            line         <= 1'b0;
            frame        <= 1'b0;
            vblank_start <= 1'b0;
            frame_cnt    <= '1;
        end else begin
            sx           <= nx;
            sy           <= ny;
            hsync        <= n_hs ? H_POL : ~H_POL;
            vsync        <= n_vs ? V_POL : ~V_POL;
            de           <= n_de;
            line         <= n_line;
            frame        <= n_frame;
            vblank_start <= n_vblank;
            if (n_frame) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule
